// File: rtl/ppm_pkg.sv
// ppm_pkg: shared constants for the PPM transmit frame sequencer.
//   - FSM state encoding
//   - default PPM_BITS / TIMEOUT_CYC
//   - symbols-per-byte constant and a helper to derive it from PPM_BITS
package ppm_pkg;

    localparam int PPM_BITS_DEF    = 2;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int SYMS_PER_BYTE   = 8 / PPM_BITS_DEF;

    function automatic int syms_per_byte(input int pb);
        return 8 / pb;
    endfunction

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SOF_REQ  = 4'd1;
    localparam logic [3:0] S_SOF_WAIT = 4'd2;
    localparam logic [3:0] S_FETCH    = 4'd3;
    localparam logic [3:0] S_SYM_REQ  = 4'd4;
    localparam logic [3:0] S_SYM_WAIT = 4'd5;
    localparam logic [3:0] S_EOF_REQ  = 4'd6;
    localparam logic [3:0] S_EOF_WAIT = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;
    localparam logic [3:0] S_ERR      = 4'd9;

endpackage

// File: rtl/ppm_tx_ctrl_if.sv
// ppm_tx_ctrl_if: byte-stream and SOF/symbol/EOF handshakes of the PPM
// frame sequencer.
//   master : the sequencer (drives byte_ready and all requests)
//   slave  : FIFO + sof/modulator/eof side (drives data and *_done)
// Signals: byte_data/byte_valid/byte_ready, control_sof/sof_done,
//          sym_val/sym_start/sym_done, control_eof/eof_done.
interface ppm_tx_ctrl_if
    import ppm_pkg::*;
#(
    parameter int PPM_BITS = PPM_BITS_DEF
);
    logic [7:0]          byte_data;
    logic                byte_valid;
    logic                byte_ready;
    logic                control_sof;
    logic                sof_done;
    logic [PPM_BITS-1:0] sym_val;
    logic                sym_start;
    logic                sym_done;
    logic                control_eof;
    logic                eof_done;

    modport master (
        input  byte_data, byte_valid, sof_done, sym_done, eof_done,
        output byte_ready, control_sof, sym_val, sym_start, control_eof
    );

    modport slave (
        output byte_data, byte_valid, sof_done, sym_done, eof_done,
        input  byte_ready, control_sof, sym_val, sym_start, control_eof
    );
endinterface

// File: rtl/ppm_byte_serializer.sv
// ppm_byte_serializer: splits a payload byte into PPM symbols, MSB first.
// Optional macro: PPM_PARITY_EN adds a running XOR of every issued data
// symbol, which can be loaded into the symbol slot as a trailing symbol.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_load       load i_byte, restart symbol count
//   i_byte       payload byte
//   i_shift      advance to next symbol of the byte
//   i_par_clr    (PPM_PARITY_EN) clear the parity accumulator
//   i_acc        (PPM_PARITY_EN) fold the current symbol into parity
//   i_par_load   (PPM_PARITY_EN) present the parity as the current symbol
//   o_sym        current symbol (top PPM_BITS of the shift register)
//   o_last_sym   current symbol is the last one of the byte
module ppm_byte_serializer
    import ppm_pkg::*;
#(
    parameter int PPM_BITS = PPM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [7:0]          i_byte,
    input  logic                i_shift,
`ifdef PPM_PARITY_EN
    input  logic                i_par_clr,
    input  logic                i_acc,
    input  logic                i_par_load,
`endif
    output logic [PPM_BITS-1:0] o_sym,
    output logic                o_last_sym
);
    localparam int SPB = syms_per_byte(PPM_BITS);

    logic [7:0] r_sh;
    logic [3:0] r_cnt;

`ifdef PPM_PARITY_EN
    logic [PPM_BITS-1:0] r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_par <= '0;
        else if (i_par_clr)  r_par <= '0;
        else if (i_acc)      r_par <= r_par ^ o_sym;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_byte;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sh  <= r_sh << PPM_BITS;
            r_cnt <= r_cnt + 4'd1;
        end
`ifdef PPM_PARITY_EN
        // Parity rides in the top bits so sym_val needs no extra mux.
        else if (i_par_load) begin
            r_sh  <= 8'(r_par) << (8 - PPM_BITS);
        end
`endif
    end

    assign o_sym      = r_sh[7 -: PPM_BITS];
    assign o_last_sym = (r_cnt == 4'(SPB - 1));
endmodule

// File: rtl/ppm_tx_ctrl.sv
// ppm_tx_ctrl: PPM transmit frame sequencer. On tx_start issues SOF, then
// pulls tx_len bytes and sends them as PPM symbols MSB first, then EOF.
// A *_WAIT that sees no done for TIMEOUT_CYC cycles aborts with tx_err.
// Optional macro: PPM_PARITY_EN sends an XOR-of-all-symbols parity symbol
// before EOF (also for an empty payload).
// Ports:
//   clk, rst            clock, async active-high reset
//   tx_start, tx_len    frame request and payload length (IDLE only)
//   tx_busy             SOF_REQ..DONE
//   tx_done, tx_err     1-cycle completion / abort pulses
//   bus (master)        byte stream + sof/sym/eof handshakes
module ppm_tx_ctrl
    import ppm_pkg::*;
#(
    parameter int PPM_BITS    = PPM_BITS_DEF,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err,
    ppm_tx_ctrl_if.master    bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]       r_state;
    logic [3:0]       w_nxt;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_last_sym;
    logic             w_bytes_rem;
    logic             w_to_hit;
    logic             w_is_req;
    logic             w_wait_idle;
    logic             w_start;

    assign w_start     = (r_state == S_IDLE) && tx_start;
    assign w_bytes_rem = (r_byte_cnt != '0);
    assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_is_req    = (r_state == S_SOF_REQ) || (r_state == S_SYM_REQ) ||
                         (r_state == S_EOF_REQ);
    // A wait cycle that produced no done advances the timeout.
    assign w_wait_idle = ((r_state == S_SOF_WAIT) && !bus.sof_done) ||
                         ((r_state == S_SYM_WAIT) && !bus.sym_done) ||
                         ((r_state == S_EOF_WAIT) && !bus.eof_done);

`ifdef PPM_PARITY_EN
    logic r_par_phase;
    logic w_par_load;
    logic w_acc;
    assign w_acc = (r_state == S_SYM_REQ) && !r_par_phase;
`endif

    always_comb begin
        w_nxt   = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
`ifdef PPM_PARITY_EN
        w_par_load = 1'b0;
`endif
        case (r_state)
            S_IDLE:     if (tx_start) w_nxt = S_SOF_REQ;
            S_SOF_REQ:  w_nxt = S_SOF_WAIT;
            S_SOF_WAIT: begin
                if (bus.sof_done) begin
                    if (w_bytes_rem) w_nxt = S_FETCH;
                    else begin
`ifdef PPM_PARITY_EN
                        w_nxt      = S_SYM_REQ;
                        w_par_load = 1'b1;
`else
                        w_nxt = S_EOF_REQ;
`endif
                    end
                end else if (w_to_hit) w_nxt = S_ERR;
            end
            S_FETCH: begin
                if (bus.byte_valid) begin
                    w_load = 1'b1;
                    w_nxt  = S_SYM_REQ;
                end
            end
            S_SYM_REQ:  w_nxt = S_SYM_WAIT;
            S_SYM_WAIT: begin
                if (bus.sym_done) begin
`ifdef PPM_PARITY_EN
                    if (r_par_phase) w_nxt = S_EOF_REQ;
                    else
`endif
                    if (!w_last_sym) begin
                        w_shift = 1'b1;
                        w_nxt   = S_SYM_REQ;
                    end else if (w_bytes_rem) w_nxt = S_FETCH;
                    else begin
`ifdef PPM_PARITY_EN
                        w_nxt      = S_SYM_REQ;
                        w_par_load = 1'b1;
`else
                        w_nxt = S_EOF_REQ;
`endif
                    end
                end else if (w_to_hit) w_nxt = S_ERR;
            end
            S_EOF_REQ:  w_nxt = S_EOF_WAIT;
            S_EOF_WAIT: begin
                if (bus.eof_done)  w_nxt = S_DONE;
                else if (w_to_hit) w_nxt = S_ERR;
            end
            S_DONE:     w_nxt = S_IDLE;
            S_ERR:      w_nxt = S_IDLE;
            default:    w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_start)     r_byte_cnt <= tx_len;
            else if (w_load) r_byte_cnt <= r_byte_cnt - 1'b1;
            if (w_is_req)         r_to_cnt <= '0;
            else if (w_wait_idle) r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

`ifdef PPM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_par_phase <= 1'b0;
        else if (r_state == S_IDLE) r_par_phase <= 1'b0;
        else if (w_par_load)        r_par_phase <= 1'b1;
    end
`endif

    ppm_byte_serializer #(.PPM_BITS(PPM_BITS)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_byte     (bus.byte_data),
        .i_shift    (w_shift),
`ifdef PPM_PARITY_EN
        .i_par_clr  (w_start),
        .i_acc      (w_acc),
        .i_par_load (w_par_load),
`endif
        .o_sym      (bus.sym_val),
        .o_last_sym (w_last_sym)
    );

    assign tx_busy         = (r_state != S_IDLE) && (r_state != S_ERR);
    assign tx_done         = (r_state == S_DONE);
    assign tx_err          = (r_state == S_ERR);
    assign bus.byte_ready  = (r_state == S_FETCH);
    assign bus.control_sof = (r_state == S_SOF_REQ);
    assign bus.sym_start   = (r_state == S_SYM_REQ);
    assign bus.control_eof = (r_state == S_EOF_REQ);
endmodule

// File: tb/tb_ppm_tx_ctrl.sv
module tb_ppm_tx_ctrl;
    import ppm_pkg::*;

    localparam int PB = 2;
    localparam int LW = 8;
    localparam int TO = 4096;

    localparam logic [2:0] K_SOF  = 3'd1;
    localparam logic [2:0] K_SYM  = 3'd2;
    localparam logic [2:0] K_EOF  = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;
    localparam logic [2:0] K_ERR  = 3'd5;

    typedef struct packed {
        logic [2:0] k;
        logic [7:0] v;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_start = 1'b0;
    logic [LW-1:0] tx_len = '0;
    logic          tx_busy, tx_done, tx_err;

    always #5 clk = ~clk;

    ppm_tx_ctrl_if #(.PPM_BITS(PB)) bus ();

    ppm_tx_ctrl #(.PPM_BITS(PB), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_len   (tx_len),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .bus      (bus)
    );

    ev_t        expq[$];
    logic [7:0] bq[$];
    int         gq[$];
    int         n_cmp = 0, n_fail = 0;
    int         cyc = 0;
    int         n_end = 0, n_err = 0, ready_cnt = 0;
    int         sof_cyc = 0, acc_cyc = 0;
    bit         pend = 0;
    bit         sof_en = 1;
    logic [PB-1:0] tb_par = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        e.k = k;
        e.v = v;
        expq.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        logic [7:0] t;
        t = b;
        bq.push_back(b);
        gq.push_back(gap);
        for (int i = 0; i < 4; i++) begin
            push(K_SYM, {6'd0, t[7:6]});
            tb_par = tb_par ^ t[7:6];
            t = t << 2;
        end
    endtask

    task automatic push_tail();
`ifdef PPM_PARITY_EN
        push(K_SYM, 8'(tb_par));
`endif
        push(K_EOF, 8'd0);
        push(K_DONE, 8'd0);
    endtask

    task automatic observe(input logic [2:0] k, input logic [7:0] v);
        ev_t e;
        if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected none", k, v);
        end else begin
            e = expq.pop_front();
            chk("event", {21'd0, k, v}, {21'd0, e.k, e.v});
        end
    endtask

    // Monitor: pop and compare on every DUT output event.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.control_sof) begin
                sof_cyc = cyc;
                observe(K_SOF, 8'd0);
            end
            if (bus.sym_start) begin
                observe(K_SYM, 8'(bus.sym_val));
                if (pend) begin
                    chk("sym_latency", 32'(cyc), 32'(acc_cyc + 1));
                    pend = 0;
                end
            end
            if (bus.control_eof) observe(K_EOF, 8'd0);
            if (tx_done) begin
                observe(K_DONE, 8'd0);
                n_end++;
            end
            if (tx_err) begin
                observe(K_ERR, 8'd0);
                chk("err_latency", 32'(cyc - sof_cyc), 32'(TO + 1));
                n_end++;
                n_err++;
            end
            if (bus.byte_ready) ready_cnt++;
            if (bus.byte_valid && bus.byte_ready) begin
                acc_cyc = cyc;
                pend = 1;
            end
        end else pend = 0;
    end

    // Byte source.
    initial begin
        bit pacc;
        pacc = 0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                bus.byte_valid = 1'b0;
                bq.delete();
                gq.delete();
                pacc = 0;
            end else begin
                if (pacc) begin
                    bus.byte_valid = 1'b0;
                    pacc = 0;
                end
                if (!bus.byte_valid && bq.size() > 0) begin
                    if (gq[0] > 0) gq[0] = gq[0] - 1;
                    else begin
                        bus.byte_data  = bq.pop_front();
                        gq.delete(0);
                        bus.byte_valid = 1'b1;
                    end
                end
                pacc = bus.byte_valid && bus.byte_ready;
            end
        end
    end

    // Responders: done 3 cycles after each request.
    initial begin
        int sc, yc, ec;
        sc = 0; yc = 0; ec = 0;
        bus.sof_done = 1'b0;
        bus.sym_done = 1'b0;
        bus.eof_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                sc = 0; yc = 0; ec = 0;
                bus.sof_done = 1'b0;
                bus.sym_done = 1'b0;
                bus.eof_done = 1'b0;
            end else begin
                if (sc > 0) begin sc--; bus.sof_done = (sc == 0); end else bus.sof_done = 1'b0;
                if (yc > 0) begin yc--; bus.sym_done = (yc == 0); end else bus.sym_done = 1'b0;
                if (ec > 0) begin ec--; bus.eof_done = (ec == 0); end else bus.eof_done = 1'b0;
                if (bus.control_sof && sof_en) sc = 3;
                if (bus.sym_start) yc = 3;
                if (bus.control_eof) ec = 3;
            end
        end
    end

    task automatic start_frame(input logic [LW-1:0] len);
        @(posedge clk); #2;
        tx_len   = len;
        tx_start = 1'b1;
        @(posedge clk); #2;
        tx_start = 1'b0;
        chk("sof_at_n_plus_1", 32'(bus.control_sof), 32'd1);
        @(posedge clk); #2;
        chk("sof_one_cycle", 32'(bus.control_sof), 32'd0);
        chk("busy_in_frame", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        int  e0;
        bit  hit;
        e0  = n_end;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (n_end != e0) hit = 1;
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_end_timeout: got no tx_done/tx_err expected one within %0d cycles", budget);
        end
        @(negedge clk);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("busy_after", 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_sym_start(input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus.sym_start) hit = 1;
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got no sym_start expected one within 200 cycles", nm);
        end
    endtask

    initial begin
        int e0;
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(tx_busy), 32'd0);
        chk("rst_done",  32'(tx_done), 32'd0);
        chk("rst_err",   32'(tx_err), 32'd0);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_sof",   32'(bus.control_sof), 32'd0);
        chk("rst_sym",   32'(bus.sym_start), 32'd0);
        chk("rst_symv",  32'(bus.sym_val), 32'd0);
        chk("rst_eof",   32'(bus.control_eof), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // 1: single byte 0xB4 -> 2,3,1,0
        tb_par = '0;
        push(K_SOF, 8'd0);
        push_byte(8'hB4, 0);
        push_tail();
        start_frame(8'd1);
        wait_end(300);

        // 2: empty payload
        tb_par = '0;
        ready_cnt = 0;
        push(K_SOF, 8'd0);
        push_tail();
        start_frame(8'd0);
        wait_end(300);
        chk("len0_no_ready", 32'(ready_cnt), 32'd0);

        // 3: two bytes, 50-cycle stall before the second
        tb_par = '0;
        e0 = n_err;
        push(K_SOF, 8'd0);
        push_byte(8'h1B, 0);
        push_byte(8'hE4, 50);
        push_tail();
        start_frame(8'd2);
        wait_end(600);
        chk("stall_no_err", 32'(n_err - e0), 32'd0);

        // 4: sof_done never arrives -> timeout
        sof_en = 0;
        push(K_SOF, 8'd0);
        push(K_ERR, 8'd0);
        start_frame(8'd1);
        wait_end(TO + 100);
        sof_en = 1;

        // 5: tx_start ignored mid-frame and in DONE; accepted right after
        tb_par = '0;
        push(K_SOF, 8'd0);
        push_byte(8'h5A, 0);
        push_tail();
        start_frame(8'd1);
        wait_sym_start("midframe_sym");
        @(posedge clk); #2;
        tx_len   = 8'd5;
        tx_start = 1'b1;
        @(posedge clk); #2;
        tx_start = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #2;
            if (tx_done) hit = 1;
        end
        chk("done_seen", 32'(hit), 32'd1);
        tb_par = '0;
        push(K_SOF, 8'd0);
        push_byte(8'h33, 0);
        push_tail();
        tx_len   = 8'd1;
        tx_start = 1'b1;
        @(posedge clk); #2;
        chk("no_sof_from_done_cycle", 32'(bus.control_sof), 32'd0);
        @(posedge clk); #2;
        chk("restart_sof", 32'(bus.control_sof), 32'd1);
        tx_start = 1'b0;
        wait_end(300);

        // 6: reset during SYM_WAIT
        tb_par = '0;
        push(K_SOF, 8'd0);
        push_byte(8'hC6, 0);
        push_tail();
        start_frame(8'd1);
        wait_sym_start("pre_reset_sym");
        e0 = n_end;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", {25'd0, tx_busy, tx_done, tx_err, bus.byte_ready,
                          bus.control_sof, bus.sym_start, bus.control_eof}, 32'd0);
        chk("arst_symv", 32'(bus.sym_val), 32'd0);
        expq.delete();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("arst_no_end", 32'(n_end - e0), 32'd0);
        tb_par = '0;
        push(K_SOF, 8'd0);
        push_byte(8'hB4, 0);
        push_tail();
        start_frame(8'd1);
        wait_end(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
